// File: rtl/serial_link_defs.sv
//-----------------------------------------------------------------------------
// Package : serial_link_defs
// Purpose : Definitions shared by the transmit and receive sides of the
//           single-wire serial link: FSM state encoding and the line levels
//           used for idle, start and stop.
// Ports   : none (package)
// Rev     : 1.0  initial release
//-----------------------------------------------------------------------------
`default_nettype none

package serial_link_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } link_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage : serial_link_defs

`default_nettype wire

// File: rtl/serial_frame_tx_bit_timer.sv
//-----------------------------------------------------------------------------
// Module  : bit_timer
// Purpose : Counts clocks 0..CLKS_PER_BIT-1 while enabled and flags the last
//           clock of each bit period. Also reports whether the *next* cycle
//           will be a bit end, so the parent can register its outputs one
//           cycle ahead.
// Ports   : clk       in  system clock
//           rst       in  synchronous active-high reset
//           clear     in  restart the count at 0 (frame accept)
//           enable    in  advance the count
//           bit_end   out current cycle is the last of a bit period
//           next_end  out next cycle will be the last of a bit period
// Rev     : 1.0  initial release
//-----------------------------------------------------------------------------
`default_nettype none

module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic bit_end,
  output logic next_end
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);

  logic [CNT_W-1:0] r_cnt;

  assign bit_end = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= bit_end ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // With one clock per bit every cycle is a bit end; otherwise the next
  // cycle ends a bit only when the count is one short of wrapping.
  generate
    if (CLKS_PER_BIT == 1) begin : g_single_clock
      assign next_end = 1'b1;
    end else begin : g_multi_clock
      assign next_end = !clear && !bit_end && (r_cnt == CNT_W'(CLKS_PER_BIT - 2));
    end
  endgenerate

endmodule : bit_timer

`default_nettype wire

// File: rtl/serial_frame_tx.sv
//-----------------------------------------------------------------------------
// Module  : serial_frame_tx
// Purpose : Serial link transmitter. Accepts a parallel word over a
//           valid/ready handshake and shifts it out as start bit (0),
//           WIDTH data bits LSB first, stop bit (1); each bit held for
//           CLKS_PER_BIT clocks. Idle line is high.
// Ports   : clock    in  system clock
//           reset    in  synchronous active-high reset
//           data_in  in  word to send, sampled on the accept cycle only
//           load     in  producer valid (accepted when load && ready)
//           ready    out idle / able to accept a word (registered)
//           tx       out serial line (registered)
//           busy     out frame in progress (registered)
//           done     out pulse on final stop-bit cycle (registered)
// Rev     : 1.0  initial release
//-----------------------------------------------------------------------------
`default_nettype none

module serial_frame_tx
  import serial_link_defs::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = $clog2(WIDTH + 1);

  link_state_t      r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [IDX_W-1:0] r_bit_idx;

  logic             w_accept;
  logic             w_bit_end;
  logic             w_next_end;
  logic [WIDTH-1:0] w_shifted;

  // ready is high only in IDLE and on the last stop cycle, so this covers
  // both the idle accept and the back-to-back accept on the done cycle.
  assign w_accept  = load && ready;
  assign w_shifted = r_shreg >> 1;

  bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clock),
    .rst      (reset),
    .clear    (w_accept),
    .enable   (r_state != IDLE),
    .bit_end  (w_bit_end),
    .next_end (w_next_end)
  );

  // Outputs are registered from the state being entered, so tx/ready/busy/
  // done line up with the state on the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_shreg   <= '0;
      r_bit_idx <= '0;
      tx        <= LINE_IDLE;
      ready     <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state   <= START;
            r_shreg   <= data_in;
            r_bit_idx <= '0;
            tx        <= START_BIT;
            ready     <= 1'b0;
            busy      <= 1'b1;
          end
        end

        START: begin
          if (w_bit_end) begin
            r_state   <= DATA;
            r_bit_idx <= '0;
            tx        <= r_shreg[0];
          end
        end

        DATA: begin
          if (w_bit_end) begin
            if (r_bit_idx == IDX_W'(WIDTH - 1)) begin
              r_state <= STOP;
              tx      <= STOP_BIT;
              // A one-clock stop bit is already its own last cycle.
              done    <= w_next_end;
              ready   <= w_next_end;
            end else begin
              r_shreg   <= w_shifted;
              r_bit_idx <= r_bit_idx + IDX_W'(1);
              tx        <= w_shifted[0];
            end
          end
        end

        STOP: begin
          if (w_bit_end) begin
            if (w_accept) begin
              // Back-to-back: start bit follows the stop bit directly.
              r_state   <= START;
              r_shreg   <= data_in;
              r_bit_idx <= '0;
              tx        <= START_BIT;
              ready     <= 1'b0;
              busy      <= 1'b1;
            end else begin
              r_state <= IDLE;
              tx      <= LINE_IDLE;
              ready   <= 1'b1;
              busy    <= 1'b0;
            end
          end else begin
            done  <= w_next_end;
            ready <= w_next_end;
          end
        end

        default: begin
          r_state <= IDLE;
          tx      <= LINE_IDLE;
          ready   <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule : serial_frame_tx

`default_nettype wire

// File: tb/tb_serial_frame_tx.sv
//-----------------------------------------------------------------------------
// Module  : tb_serial_frame_tx
// Purpose : Self-checking bench for serial_frame_tx. One instance with
//           WIDTH=8/CLKS_PER_BIT=4 driven from a table of frames plus hand
//           sequences; a second instance with WIDTH=4/CLKS_PER_BIT=1.
// Rev     : 1.0  initial release
//-----------------------------------------------------------------------------
`default_nettype none

module tb_serial_frame_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       load;
  logic       ready, tx, busy, done;

  logic [3:0] data2;
  logic       load2;
  logic       ready2, tx2, busy2, done2;

  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;

  always #5 clk = ~clk;

  serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) u_dut (
    .clock   (clk),
    .reset   (reset),
    .data_in (data_in),
    .load    (load),
    .ready   (ready),
    .tx      (tx),
    .busy    (busy),
    .done    (done)
  );

  serial_frame_tx #(.WIDTH(4), .CLKS_PER_BIT(1)) u_dut_fast (
    .clock   (clk),
    .reset   (reset),
    .data_in (data2),
    .load    (load2),
    .ready   (ready2),
    .tx      (tx2),
    .busy    (busy2),
    .done    (done2)
  );

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;    // bit k = k-th bit on the line (start first)
    int         pulse_at; // frame cycle to drive load (0 = none, 40 = chain)
    logic [7:0] pulse_d;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // {tx, busy, ready, done}
  task automatic check_idle(input string name);
    check(name, {28'd0, tx, busy, ready, done}, 32'b1010);
  endtask

  task automatic issue_load(input logic [7:0] d);
    @(negedge clk);
    check("ready_before_load", {31'd0, ready}, 32'd1);
    load    = 1'b1;
    data_in = d;
  endtask

  // Observes frame cycles 1..last after an accept. Drives load only on
  // cycle pulse_at; data_in is scrambled otherwise to show it is ignored.
  task automatic watch_frame(input logic [9:0] frame, input int last,
                             input int pulse_at, input logic [7:0] pulse_d);
    int   dones;
    logic last_c;
    dones = 0;
    for (int i = 1; i <= last; i++) begin
      @(negedge clk);
      last_c = (i == 40);
      check($sformatf("frame_cycle_%0d", i), {28'd0, tx, busy, ready, done},
            {28'd0, frame[(i-1)/4], 1'b1, last_c, last_c});
      if (busy) busy_cnt++;
      if (done) dones++;
      load = (i == pulse_at);
      data_in = (i == pulse_at) ? pulse_d : 8'($urandom);
    end
    if (last == 40) check("done_count", dones, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [5:0] fast_frame;

    tbl[0] = '{8'hA5, 10'b1101001010, 0,  8'h00};
    tbl[1] = '{8'h00, 10'b1000000000, 40, 8'hFF};
    tbl[2] = '{8'hFF, 10'b1111111110, 0,  8'h00};
    tbl[3] = '{8'h81, 10'b1100000010, 15, 8'h3C};
    tbl[4] = '{8'h3C, 10'b1001111000, 0,  8'h00};

    reset   = 1'b1;
    load    = 1'b0;
    data_in = 8'h00;
    load2   = 1'b0;
    data2   = 4'h0;

    // Reset held 3 cycles with load toggling: nothing may be accepted.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle("reset_hold");
      load    = (i != 1);
      data_in = 8'hA5;
    end
    reset = 1'b0;
    load  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_idle("after_reset");
    end

    // Table-driven frames.
    for (int v = 0; v < 5; v++) begin
      if (v == 1) busy_cnt = 0;
      if (!(v > 0 && tbl[v-1].pulse_at == 40)) issue_load(tbl[v].data);
      watch_frame(tbl[v].frame, 40, tbl[v].pulse_at, tbl[v].pulse_d);
      if (v == 2) check("b2b_busy_cycles", busy_cnt, 80);
      if (tbl[v].pulse_at != 40) begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check_idle($sformatf("idle_after_vec%0d", v));
        end
      end
    end

    // Reset during data bit 3 of 8'h55 (frame cycles 17..20), with a load
    // coincident with the reset that must be dropped.
    issue_load(8'h55);
    watch_frame(10'b1010101010, 18, 0, 8'h00);
    reset   = 1'b1;
    load    = 1'b1;
    data_in = 8'hAA;
    @(negedge clk);
    check_idle("mid_frame_reset");
    reset = 1'b0;
    load  = 1'b0;
    for (int k = 0; k < 44; k++) begin
      @(negedge clk);
      check_idle("no_done_after_abort");
    end
    issue_load(8'h0F);
    watch_frame(10'b1000011110, 40, 0, 8'h00);
    @(negedge clk);
    check_idle("idle_after_0f");

    // One clock per bit, WIDTH=4: 4'b1001 -> 0,1,0,0,1,1.
    fast_frame = 6'b110010;
    @(negedge clk);
    check("fast_ready", {31'd0, ready2}, 32'd1);
    load2 = 1'b1;
    data2 = 4'b1001;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      load2 = 1'b0;
      data2 = 4'($urandom);
      check($sformatf("fast_cycle_%0d", i), {28'd0, tx2, busy2, ready2, done2},
            {28'd0, fast_frame[i-1], 1'b1, (i == 6), (i == 6)});
    end
    @(negedge clk);
    check("fast_idle", {28'd0, tx2, busy2, ready2, done2}, 32'b1010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_serial_frame_tx

`default_nettype wire
